// File: rtl/router_arb_pkg.sv
// Shared types for router_lookup_arbiter: FSM encoding, flag bit positions,
// and the registered response bundle.
package router_arb_pkg;

  localparam logic [1:0] ST_WAIT_INIT = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_FAIL      = 2'd2;

  localparam int FLAG_DIRECT  = 0;
  localparam int FLAG_BCAST   = 1;
  localparam int FLAG_DEFAULT = 2;

  typedef struct packed {
    logic        found;
    logic [15:0] out_port;
    logic [15:0] out_qp;
    logic [31:0] next_hop_ip;
    logic [47:0] next_hop_mac;
    logic [2:0]  flags;
  } rt_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant on the first valid requester at or after
// ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [REQ_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   winner
);

  logic [REQ_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest valid one wins last.
  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = REQ_W'((int'(ptr) + off) % NUM_REQ);
      if (en && valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/router_lookup_arbiter.sv
// Shares one in-order routing lookup pipeline among NUM_REQ requesters and
// steers responses back via a tag FIFO. Perf counters under ROUTER_ARB_PERF_EN.
module router_lookup_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REQ_W      = $clog2(NUM_REQ),
  parameter int RT_LATENCY = 3,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_dst_ip,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_found,
  output logic [15:0]           rsp_out_port,
  output logic [15:0]           rsp_out_qp,
  output logic [31:0]           rsp_next_hop_ip,
  output logic [47:0]           rsp_next_hop_mac,
  output logic [2:0]            rsp_flags,
  output logic                  rt_lookup_valid,
  output logic [31:0]           rt_lookup_dst_ip,
  input  logic                  rt_resp_valid,
  input  logic                  rt_resp_found,
  input  logic [15:0]           rt_resp_out_port,
  input  logic [15:0]           rt_resp_out_qp,
  input  logic [31:0]           rt_resp_next_hop_ip,
  input  logic [47:0]           rt_resp_next_hop_mac,
  input  logic [2:0]            rt_resp_flags,
  input  logic                  rt_init_done,
  input  logic                  rt_init_error,
  output logic [1:0]            arb_state,
  output logic                  err_orphan,
  output logic                  err_init,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  if (TAG_DEPTH < RT_LATENCY + 2) begin : g_depth_chk
    $error("TAG_DEPTH below RT_LATENCY+2 cannot sustain one lookup per cycle");
  end

  logic [1:0]                 state;
  logic [REQ_W-1:0]           rr_ptr, winner;
  logic [NUM_REQ-1:0]         grant, head_oh;
  logic [NUM_REQ-1:0][31:0]   ip_arr;
  logic [REQ_W-1:0]           tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       grant_en, accept, pop;
  rt_rsp_t                    rsp_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ip_arr    = req_dst_ip;
  assign grant_en  = (state == ST_RUN) && (count < CNT_W'(TAG_DEPTH));
  assign accept    = |grant;
  assign pop       = rt_resp_valid && (count != '0);
  assign req_ready = grant;
  assign arb_state = state;
  assign err_init  = (state == ST_FAIL);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .en    (grant_en),
    .grant (grant),
    .winner(winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT_INIT;
    end else begin
      case (state)
        ST_WAIT_INIT: if (rt_init_error) state <= ST_FAIL;
                      else if (rt_init_done) state <= ST_RUN;
        ST_RUN:       if (rt_init_error) state <= ST_FAIL;
        default:      state <= ST_FAIL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      rt_lookup_valid  <= 1'b0;
      rt_lookup_dst_ip <= '0;
    end else begin
      rt_lookup_valid <= accept;
      if (accept) begin
        rr_ptr           <= (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + REQ_W'(1);
        rt_lookup_dst_ip <= ip_arr[winner];
      end
    end
  end

  // Tag FIFO: full/empty decisions use the count as it stood before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= winner;
  end

  always_comb begin
    head_oh                  = '0;
    head_oh[tag_mem[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_q      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop ? head_oh : '0;
      if (pop)
        rsp_q <= '{found: rt_resp_found, out_port: rt_resp_out_port,
                   out_qp: rt_resp_out_qp, next_hop_ip: rt_resp_next_hop_ip,
                   next_hop_mac: rt_resp_next_hop_mac, flags: rt_resp_flags};
      if (rt_resp_valid && count == '0) err_orphan <= 1'b1;
    end
  end

  assign rsp_found        = rsp_q.found;
  assign rsp_out_port     = rsp_q.out_port;
  assign rsp_out_qp       = rsp_q.out_qp;
  assign rsp_next_hop_ip  = rsp_q.next_hop_ip;
  assign rsp_next_hop_mac = rsp_q.next_hop_mac;
  assign rsp_flags        = rsp_q.flags;

`ifdef ROUTER_ARB_PERF_EN
  logic stall;
  assign stall = (state == ST_RUN) && (|req_valid) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (stall && perf_stall != '1)   perf_stall  <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_router_lookup_arbiter.sv
// Randomized bench for router_lookup_arbiter with a queue-based router and
// scoreboard model; perf counters checked when ROUTER_ARB_PERF_EN is defined.
module tb_router_lookup_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst_n;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*32-1:0] req_dst_ip;
  logic rsp_found, rt_lookup_valid, rt_resp_valid, rt_resp_found;
  logic [15:0] rsp_out_port, rsp_out_qp, rt_resp_out_port, rt_resp_out_qp;
  logic [31:0] rsp_next_hop_ip, rt_lookup_dst_ip, rt_resp_next_hop_ip;
  logic [47:0] rsp_next_hop_mac, rt_resp_next_hop_mac;
  logic [2:0] rsp_flags, rt_resp_flags;
  logic rt_init_done, rt_init_error, err_orphan, err_init;
  logic [1:0] arb_state;
  logic [31:0] perf_issued, perf_stall;

  router_lookup_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dst_ip(req_dst_ip),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_found(rsp_found),
    .rsp_out_port(rsp_out_port), .rsp_out_qp(rsp_out_qp),
    .rsp_next_hop_ip(rsp_next_hop_ip), .rsp_next_hop_mac(rsp_next_hop_mac),
    .rsp_flags(rsp_flags), .rt_lookup_valid(rt_lookup_valid),
    .rt_lookup_dst_ip(rt_lookup_dst_ip), .rt_resp_valid(rt_resp_valid),
    .rt_resp_found(rt_resp_found), .rt_resp_out_port(rt_resp_out_port),
    .rt_resp_out_qp(rt_resp_out_qp), .rt_resp_next_hop_ip(rt_resp_next_hop_ip),
    .rt_resp_next_hop_mac(rt_resp_next_hop_mac), .rt_resp_flags(rt_resp_flags),
    .rt_init_done(rt_init_done), .rt_init_error(rt_init_error),
    .arb_state(arb_state), .err_orphan(err_orphan), .err_init(err_init),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ip; int due; } rt_ent_t;
  typedef struct { int idx; logic [31:0] ip; } exp_t;
  typedef struct { logic [N-1:0] vec; logic [115:0] data; int cyc; } obs_t;

  rt_ent_t rt_q[$];
  exp_t    exp_q[$];
  obs_t    obs_q[$];
  logic [31:0] rq_ip [N];
  int  cyc = 0, passed = 0, total = 0;
  int  m_ptr = 0, m_cnt = 0, m_issued = 0, m_stall = 0;
  bit  m_run = 0, hold = 0;

  // Router response content as a pure function of the looked-up address.
  function automatic logic [115:0] route_of(input logic [31:0] ip);
    return {ip[3] ^ ip[12], ip[15:0] ^ 16'h5a5a, ip[31:16], ~ip, {ip[15:0], ip},
            ip[2:0] ^ ip[10:8]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, output int exp);
    for (int k = 0; k < N; k++) begin
      rq_ip[k] = $urandom;
      req_dst_ip[32*k +: 32] = rq_ip[k];
    end
    req_valid = v;
    #1;
    exp = (m_run && m_cnt < DEPTH) ? rr_pick(v, m_ptr) : -1;
    if (m_run && v != '0 && exp < 0) m_stall++;
  endtask

  // Advance one clock; keep the model in step and play the router.
  task automatic tick(input int acc);
    logic resp_now;
    resp_now = rt_resp_valid;
    @(posedge clk); #1;
    cyc++;
    if (resp_now) begin
      if (m_cnt > 0) m_cnt--;
      if (rt_q.size() > 0) void'(rt_q.pop_front());
    end
    if (acc >= 0) begin
      m_cnt++; m_issued++; m_ptr = (acc + 1) % N;
      exp_q.push_back('{acc, rq_ip[acc]});
    end
    if (rt_lookup_valid) rt_q.push_back('{rt_lookup_dst_ip, cyc + 3});
    if (rsp_valid != '0)
      obs_q.push_back('{rsp_valid, {rsp_found, rsp_out_port, rsp_out_qp,
                        rsp_next_hop_ip, rsp_next_hop_mac, rsp_flags}, cyc});
    if (!hold && rt_q.size() > 0 && rt_q[0].due <= cyc) begin
      rt_resp_valid = 1'b1;
      {rt_resp_found, rt_resp_out_port, rt_resp_out_qp, rt_resp_next_hop_ip,
       rt_resp_next_hop_mac, rt_resp_flags} = route_of(rt_q[0].ip);
    end else begin
      rt_resp_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    req_valid = '0;
    hold = 0;
    while ((m_cnt > 0 || rt_q.size() > 0 || rt_resp_valid) && n < 200) begin
      tick(-1); n++;
    end
    repeat (2) tick(-1);
    ok = (n < 200);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_dst_ip = '0; rt_resp_valid = 0;
    rt_resp_found = 0; rt_resp_out_port = 0; rt_resp_out_qp = 0;
    rt_resp_next_hop_ip = 0; rt_resp_next_hop_mac = 0; rt_resp_flags = 0;
    rt_init_done = 0; rt_init_error = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rt_lookup_valid, arb_state, err_orphan, err_init,
         perf_issued, perf_stall} !== '0) begin
      $display("FAIL reset_outputs got rdy=%b rsp=%b lk=%b st=%0d eo=%b ei=%b pi=%0d ps=%0d exp all 0",
               req_ready, rsp_valid, rt_lookup_valid, arb_state, err_orphan,
               err_init, perf_issued, perf_stall);
    end else passed++;
    rst_n = 1'b1; req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_init_gating();
    int e;
    logic [N-1:0] em;
    repeat (20) begin
      drive(4'b0001, e);
      total++;
      if (req_ready !== '0 || arb_state !== 2'd0) begin
        $display("FAIL init_gate got rdy=%b st=%0d exp rdy=0000 st=0", req_ready, arb_state);
      end else passed++;
      tick(e);
    end
    rt_init_done = 1'b1;
    drive(4'b0001, e);
    tick(e);
    m_run = 1;
    drive(4'b0001, e);
    em = (e < 0) ? '0 : (4'b0001 << e);
    total++;
    if (req_ready !== em || arb_state !== 2'd1) begin
      $display("FAIL init_release got rdy=%b st=%0d exp rdy=%b st=1", req_ready, arb_state, em);
    end else passed++;
    req_valid = '0; #1;
    tick(-1);
  endtask

  task automatic test_single();
    int e, t;
    logic [115:0] want;
    obs_t o;
    drive(4'b0001, e);
    rq_ip[0] = 32'h0a32b7fa; req_dst_ip[31:0] = 32'h0a32b7fa; #1;
    want = route_of(32'h0a32b7fa);
    total++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", req_ready);
    else passed++;
    t = cyc;
    tick(e);
    req_valid = '0;
    total++;
    if (rt_lookup_valid !== 1'b1 || rt_lookup_dst_ip !== 32'h0a32b7fa)
      $display("FAIL single_issue got v=%b ip=%h exp v=1 ip=0a32b7fa", rt_lookup_valid, rt_lookup_dst_ip);
    else passed++;
    repeat (5) tick(-1);
    total++;
    if (obs_q.size() != 1) $display("FAIL single_rsp_count got=%0d exp=1", obs_q.size());
    else begin
      o = obs_q.pop_front();
      if (o.vec !== 4'b0001 || o.cyc != t + 5 || o.data !== want)
        $display("FAIL single_rsp got vec=%b cyc=%0d data=%h exp vec=0001 cyc=%0d data=%h",
                 o.vec, o.cyc, o.data, t + 5, want);
      else passed++;
    end
    total++;
    if (rsp_valid !== '0 || rsp_out_port !== want[114:99] || rsp_flags !== want[2:0])
      $display("FAIL single_hold got v=%b port=%h flags=%b exp v=0 port=%h flags=%b",
               rsp_valid, rsp_out_port, rsp_flags, want[114:99], want[2:0]);
    else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_round_robin();
    int e;
    bit ok;
    obs_t o;
    exp_t x;
    logic [N-1:0] em;
    repeat (8) begin
      drive(4'b1111, e);
      em = (e < 0) ? '0 : (4'b0001 << e);
      total++;
      if (req_ready !== em) $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready, em);
      else passed++;
      tick(e);
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL rr_rsp_count got=%0d exp=%0d drained=%0d", obs_q.size(), exp_q.size(), ok);
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      em = 4'b0001 << x.idx;
      total++;
      if (o.vec !== em || o.data !== route_of(x.ip))
        $display("FAIL rr_rsp got vec=%b data=%h exp vec=%b data=%h", o.vec, o.data, em, route_of(x.ip));
      else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int e, acc = 0;
    bit ok;
    obs_t o;
    exp_t x;
    logic [31:0] ei, es;
    repeat (16) begin
      drive(4'b0100, e);
      total++;
      if (req_ready !== 4'b0100) $display("FAIL b2b_grant cyc=%0d got=%b exp=0100", cyc, req_ready);
      else passed++;
      if (e >= 0) acc++;
      tick(e);
    end
    drain(ok);
    total++;
    if (!ok || acc != 16 || obs_q.size() != 16)
      $display("FAIL b2b_count got acc=%0d rsp=%0d exp 16/16", acc, obs_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      total++;
      if (o.vec !== 4'b0100 || o.data !== route_of(x.ip))
        $display("FAIL b2b_rsp got vec=%b data=%h exp vec=0100 data=%h", o.vec, o.data, route_of(x.ip));
      else passed++;
    end
    obs_q.delete(); exp_q.delete();
`ifdef ROUTER_ARB_PERF_EN
    ei = m_issued; es = m_stall;
`else
    ei = 0; es = 0;
`endif
    total++;
    if (perf_issued !== ei || perf_stall !== es)
      $display("FAIL b2b_perf got issued=%0d stall=%0d exp issued=%0d stall=%0d", perf_issued, perf_stall, ei, es);
    else passed++;
  endtask

  task automatic test_full_fifo();
    int e;
    bit ok;
    obs_t o;
    exp_t x;
    logic [N-1:0] em;
    logic [31:0] ei, es;
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 12) hold = 0;
      drive(N'($urandom_range(1, 15)), e);
      em = (e < 0) ? '0 : (4'b0001 << e);
      total++;
      if (req_ready !== em)
        $display("FAIL full_grant cyc=%0d got=%b exp=%b outstanding=%0d", cyc, req_ready, em, m_cnt);
      else passed++;
      tick(e);
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL full_rsp_count got=%0d exp=%0d drained=%0d", obs_q.size(), exp_q.size(), ok);
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      em = 4'b0001 << x.idx;
      total++;
      if (o.vec !== em || o.data !== route_of(x.ip))
        $display("FAIL full_rsp got vec=%b data=%h exp vec=%b data=%h", o.vec, o.data, em, route_of(x.ip));
      else passed++;
    end
    obs_q.delete(); exp_q.delete();
`ifdef ROUTER_ARB_PERF_EN
    ei = m_issued; es = m_stall;
`else
    ei = 0; es = 0;
`endif
    total++;
    if (perf_issued !== ei || perf_stall !== es)
      $display("FAIL full_perf got issued=%0d stall=%0d exp issued=%0d stall=%0d", perf_issued, perf_stall, ei, es);
    else passed++;
  endtask

  task automatic test_random();
    int e;
    bit ok;
    obs_t o;
    exp_t x;
    logic [N-1:0] em;
    repeat (150) begin
      hold = ($urandom_range(0, 3) == 0);
      drive(N'($urandom_range(0, 15)), e);
      em = (e < 0) ? '0 : (4'b0001 << e);
      total++;
      if (req_ready !== em) $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, em);
      else passed++;
      tick(e);
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size())
      $display("FAIL rand_rsp_count got=%0d exp=%0d drained=%0d", obs_q.size(), exp_q.size(), ok);
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      em = 4'b0001 << x.idx;
      total++;
      if (o.vec !== em || o.data !== route_of(x.ip))
        $display("FAIL rand_rsp got vec=%b data=%h exp vec=%b data=%h", o.vec, o.data, em, route_of(x.ip));
      else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_orphan();
    total++;
    if (err_orphan !== 1'b0) $display("FAIL orphan_pre got=%b exp=0", err_orphan);
    else passed++;
    rt_resp_valid = 1'b1; rt_resp_out_port = 16'hbeef;
    tick(-1);
    total++;
    if (err_orphan !== 1'b1 || rsp_valid !== '0)
      $display("FAIL orphan_flag got eo=%b rsp=%b exp eo=1 rsp=0000", err_orphan, rsp_valid);
    else passed++;
    tick(-1);
    total++;
    if (rsp_valid !== '0 || obs_q.size() != 0 || err_orphan !== 1'b1)
      $display("FAIL orphan_quiet got rsp=%b n=%0d eo=%b exp rsp=0000 n=0 eo=1", rsp_valid, obs_q.size(), err_orphan);
    else passed++;
  endtask

  task automatic test_init_error();
    int e;
    bit ok;
    obs_t o;
    exp_t x;
    logic [N-1:0] em;
    repeat (3) begin drive(4'b1111, e); tick(e); end
    rt_init_error = 1'b1;
    drive(4'b1111, e);
    em = (e < 0) ? '0 : (4'b0001 << e);
    total++;
    if (req_ready !== em) $display("FAIL err_last_grant got=%b exp=%b", req_ready, em);
    else passed++;
    tick(e);
    rt_init_error = 1'b0;
    m_run = 0;
    repeat (5) begin
      drive(4'b1111, e);
      total++;
      if (req_ready !== '0 || arb_state !== 2'd2 || err_init !== 1'b1)
        $display("FAIL err_state got rdy=%b st=%0d ei=%b exp rdy=0000 st=2 ei=1", req_ready, arb_state, err_init);
      else passed++;
      tick(e);
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != exp_q.size() || exp_q.size() != 4)
      $display("FAIL err_inflight got=%0d exp=%0d drained=%0d", obs_q.size(), exp_q.size(), ok);
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      em = 4'b0001 << x.idx;
      total++;
      if (o.vec !== em || o.data !== route_of(x.ip))
        $display("FAIL err_rsp got vec=%b data=%h exp vec=%b data=%h", o.vec, o.data, em, route_of(x.ip));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_full_fifo();
    test_random();
    test_orphan();
    test_init_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/router_lookup_arbiter.md
Name: router_lookup_arbiter

Overview:
Shares a single routing-table lookup pipeline (3-stage, in-order, no backpressure) among NUM_REQ requesters, e.g. per-port QP engines.
- Round-robin arbitration; at most one lookup issued per cycle.
- Each issued lookup is tagged with its requester index in an in-order tag FIFO.
- Each router response is steered back to the requester that issued it.
- No grants are made until the router reports table initialisation complete.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_W, 2, requester index width, clog2(NUM_REQ)
RT_LATENCY, 3, router cycles from lookup_valid to resp_valid
TAG_DEPTH, 8, tag FIFO entries; must be >= RT_LATENCY+2 for full rate

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester lookup request
req_dst_ip  in  NUM_REQ*32  per-requester destination IP; slice i = [32*i+31:32*i]
req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready
rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle
rsp_found  out  1  route found
rsp_out_port  out  16  egress port
rsp_out_qp  out  16  egress QP
rsp_next_hop_ip  out  32  next-hop IP
rsp_next_hop_mac  out  48  next-hop MAC
rsp_flags  out  3  {is_default_route, is_broadcast, is_direct_host}
rt_lookup_valid  out  1  to router lookup_valid
rt_lookup_dst_ip  out  32  to router lookup_dst_ip
rt_resp_valid, rt_resp_found  in  1 each  from router
rt_resp_out_port, rt_resp_out_qp  in  16 each  from router
rt_resp_next_hop_ip  in  32  from router
rt_resp_next_hop_mac  in  48  from router
rt_resp_flags  in  3  from router, same order as rsp_flags
rt_init_done, rt_init_error  in  1 each  from router
arb_state  out  2  current FSM state
err_orphan  out  1  sticky: response received with tag FIFO empty
err_init  out  1  sticky: router initialisation failed

Behaviour:
- Reset: all outputs 0; FSM = WAIT_INIT; tag FIFO empty; round-robin pointer = 0.
- FSM states and transitions:
  - WAIT_INIT (0): no grants. On rt_init_error go to FAIL; else on rt_init_done go to RUN.
  - RUN (1): arbitration active. On rt_init_error go to FAIL.
  - FAIL (2): no grants, err_init = 1. Exit only by reset.
- Grant (RUN only, and only while FIFO count < TAG_DEPTH):
  - req_ready is combinational: one-hot on the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - On accept, pointer <= winner+1, wrapping to 0 after NUM_REQ-1.
  - Requesters that are not valid are skipped; a single active requester may win every cycle.
- Issue: registered. rt_lookup_valid and rt_lookup_dst_ip are driven the cycle after accept; the winner index is pushed to the tag FIFO in the accept cycle.
- Return:
  - On rt_resp_valid, pop the FIFO head and register all response fields.
  - Next cycle: rsp_valid[head] = 1 for exactly one cycle.
  - Data outputs hold their last value when rsp_valid = 0.
- Total latency: accept cycle T -> rsp_valid at T+RT_LATENCY+2 (T+5 by default).
- Push and pop in the same cycle: count is unchanged. Full condition is evaluated on the pre-update count, with no bypass.
- Orphan response (rt_resp_valid with FIFO empty): drop it, set err_orphan, emit no rsp_valid.
- FSM entering FAIL with lookups in flight: in-flight responses are still delivered; no new grants.
- Reset mid-operation: FIFO cleared; in-flight results are lost. Any late rt_resp_valid after reset raises err_orphan.

Optional Feature:
ROUTER_ARB_PERF_EN:
- Defined: adds outputs perf_issued (32) and perf_stall (32).
  - perf_issued counts accepts.
  - perf_stall counts cycles in RUN where any req_valid is high but no grant was made (FIFO full).
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports present, tied to 0, no counter logic.

Decomposition:
- Package router_arb_pkg holds:
  - FSM state encoding (WAIT_INIT = 0, RUN = 1, FAIL = 2)
  - flag bit indices (DIRECT = 0, BCAST = 1, DEFAULT = 2)
  - typedef of the response bundle
- One sub-module: rr_arbiter (NUM_REQ; inputs valid vector, pointer, enable; output one-hot grant and winner index).
- The tag FIFO is inline.

Test Plan:
- Init gating: hold rt_init_done = 0 for 20 cycles with req_valid = 4'b0001 -> req_ready = 0 throughout and arb_state = 0; raise rt_init_done -> grant the next cycle, arb_state = 1.
- Single lookup: req0 dst 0x0a32b7fa accepted at T -> rt_lookup_valid at T+1 with IP 0x0a32b7fa; model response at T+4 (port 1, qp 2, flags 3'b001) -> rsp_valid = 4'b0001 at T+5 with matching fields.
- Round-robin: all four requesters valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; responses return in the same order; rsp_valid bit i matches the issuing requester.
- Back-to-back throughput: req2 valid for 16 cycles -> 16 accepts in 16 cycles, 16 rsp_valid pulses, no stall cycles (perf_stall = 0 when ROUTER_ARB_PERF_EN is defined).
- Full FIFO: router model delays responses so 8 lookups are outstanding -> req_ready = 0 while count = 8; the first response pops one entry -> a grant resumes the next cycle.
- Errors: rt_init_error pulse during RUN -> arb_state = 2, err_init = 1, no further grants. Separately, rt_resp_valid with FIFO empty -> err_orphan = 1 and rsp_valid stays 0.
